// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache between the CPU load/store port
// and DataMem; refills 4-word blocks on read miss and counts read hits/misses.
module cache_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LINES  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES][4];
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [1:0]       cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             hit;
    logic             read_hit;

    assign cpu_off  = cpu_addr[1:0];
    assign cpu_idx  = cpu_addr[IDX_W+1:2];
    assign cpu_tag  = cpu_addr[ADDR_W-1:IDX_W+2];
    assign hit      = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign read_hit = (state == IDLE) && cpu_read && !cpu_write && hit;

    // In IDLE the stall and load data depend on the live lookup so hits never stall.
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        case (state)
            IDLE: begin
                cpu_stall = cpu_write || (cpu_read && !hit);
                if (read_hit)
                    cpu_rdata = data_arr[cpu_idx][cpu_off];
            end
            REFILL, WRITE: cpu_stall = 1'b1;
            default:       cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            req_idx    <= '0;
            req_tag    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        mem_write <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        state     <= WRITE;
                    end else if (cpu_read) begin
                        if (hit) begin
                            if (hit_count != '1)
                                hit_count <= hit_count + 1'b1;
                        end else begin
                            req_idx  <= cpu_idx;
                            req_tag  <= cpu_tag;
                            mem_read <= 1'b1;
                            mem_addr <= {cpu_tag, cpu_idx, 2'b00};
                            if (miss_count != '1)
                                miss_count <= miss_count + 1'b1;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        mem_read       <= 1'b0;
                        valid[req_idx] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage need no reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && cpu_write && hit)
                data_arr[cpu_idx][cpu_off] <= cpu_wdata;
            if (state == REFILL && mem_ready) begin
                tag_arr[req_idx]     <= req_tag;
                data_arr[req_idx][0] <= mem_rdata[31:0];
                data_arr[req_idx][1] <= mem_rdata[63:32];
                data_arr[req_idx][2] <= mem_rdata[95:64];
                data_arr[req_idx][3] <= mem_rdata[127:96];
            end
        end
    end

endmodule
